rtc_cascade_counter: RTL and testbench

- Parametrised chain of STAGES modulo counters, e.g. seconds/minutes/hours, generalising the team's fixed 4-bit wrap-at-15 counter.
- Each stage has its own modulus and supports up/down counting, parallel load, per-stage carry outputs and a registered full-chain wrap pulse.
- Sits between the RTC tick prescaler (drives en) and the display/alarm logic (reads count, wrap).

---
 rtl/rtc_pkg.sv | 17 +
 rtl/rtc_cascade_counter_if.sv | 27 ++
 rtl/rtc_mod_stage.sv | 50 +++++
 rtl/rtc_cascade_counter.sv | 73 +++++++
 tb/tb_rtc_cascade_counter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and helpers for the cascaded RTC counter.
// Moduli are packed as 8-bit fields, stage 0 in the least significant byte.
package rtc_pkg;

   localparam int MOD_FIELD_W = 8;
   localparam int MAX_STAGES  = 32;

   localparam logic [23:0] RTC_HMS_MODULI = {8'd24, 8'd60, 8'd60};

   function automatic int unsigned mod_of(
      input logic [MAX_STAGES*MOD_FIELD_W-1:0] moduli,
      input int                                k
   );
      return 32'(moduli[k*MOD_FIELD_W +: MOD_FIELD_W]);
   endfunction

endpackage

// File: rtl/rtc_cascade_counter_if.sv
// Control and status bundle between the tick prescaler, the counter chain
// and the display/alarm logic.
interface rtc_cascade_counter_if #(
   parameter int STAGES = 3,
   parameter int WIDTH  = 6
);

   logic                    en;
   logic                    up_dn;
   logic                    load;
   logic [STAGES*WIDTH-1:0] load_val;
   logic [STAGES*WIDTH-1:0] count;
   logic [STAGES-1:0]       carry;
   logic                    wrap;
   logic                    load_err;

   modport master (
      output en, up_dn, load, load_val,
      input  count, carry, wrap, load_err
   );

   modport slave (
      input  en, up_dn, load, load_val,
      output count, carry, wrap, load_err
   );

endinterface

// File: rtl/rtc_mod_stage.sv
// One modulo-MOD up/down counter stage with saturating parallel load.
// Arithmetic runs one bit wider than the stored value so MOD = 2^WIDTH works.
module rtc_mod_stage
   import rtc_pkg::*;
#(
   parameter int          WIDTH = 6,
   parameter int unsigned MOD   = 60
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value,
   output logic             at_terminal,
   output logic             sat
);

   localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MOD - 1);

   logic [WIDTH:0]   cur;
   logic [WIDTH:0]   ld;
   logic [WIDTH-1:0] nxt;

   assign cur         = {1'b0, value};
   assign ld          = {1'b0, load_val};
   assign at_terminal = up_dn ? (cur == MAX_V) : (cur == '0);
   assign sat         = (ld > MAX_V);

   always_comb begin
      nxt = value;
      if (up_dn) begin
         nxt = (cur == MAX_V) ? '0 : WIDTH'(cur + (WIDTH+1)'(1));
      end else begin
         nxt = (cur == '0) ? MAX_V[WIDTH-1:0] : WIDTH'(cur - (WIDTH+1)'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         value <= '0;
      end else if (load) begin
         value <= sat ? MAX_V[WIDTH-1:0] : load_val;
      end else if (step) begin
         value <= nxt;
      end
   end

endmodule

// File: rtl/rtc_cascade_counter.sv
// Parametrised cascade of modulo counters (e.g. hh:mm:ss) with carry chain,
// registered full-chain wrap pulse and load range error pulse.
module rtc_cascade_counter
   import rtc_pkg::*;
#(
   parameter int                              STAGES = 3,
   parameter int                              WIDTH  = 6,
   parameter logic [STAGES*MOD_FIELD_W-1:0]   MODULI = RTC_HMS_MODULI
) (
   input  logic                  clk,
   input  logic                  rst,
   rtc_cascade_counter_if.slave  bus
);

   localparam logic [MAX_STAGES*MOD_FIELD_W-1:0] MODULI_EXT =
      (MAX_STAGES*MOD_FIELD_W)'(MODULI);

   logic [STAGES-1:0]       at_term;
   logic [STAGES-1:0]       sat;
   logic [STAGES-1:0]       step;
   logic [STAGES-1:0]       carry;
   logic [STAGES*WIDTH-1:0] count;
   logic                    run;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned MOD_K = mod_of(MODULI_EXT, k);

      if (MOD_K < 2 || MOD_K > (1 << WIDTH)) begin : g_bad_mod
         $fatal(1, "rtc_cascade_counter: stage %0d modulus %0d outside 2..2^WIDTH", k, MOD_K);
      end

      rtc_mod_stage #(
         .WIDTH (WIDTH),
         .MOD   (MOD_K)
      ) u_stage (
         .clk         (clk),
         .rst         (rst),
         .step        (step[k]),
         .up_dn       (bus.up_dn),
         .load        (bus.load),
         .load_val    (bus.load_val[WIDTH*k +: WIDTH]),
         .value       (count[WIDTH*k +: WIDTH]),
         .at_terminal (at_term[k]),
         .sat         (sat[k])
      );
   end

   // A stage advances only when every lower stage is about to roll over.
   always_comb begin
      run   = bus.en & ~bus.load;
      carry = '0;
      step  = '0;
      for (int i = 0; i < STAGES; i++) begin
         step[i]  = (i == 0) ? bus.en : carry[i-1];
         run      = run & at_term[i];
         carry[i] = run;
      end
   end

   assign bus.count = count;
   assign bus.carry = carry;

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.wrap     <= 1'b0;
         bus.load_err <= 1'b0;
      end else begin
         bus.wrap     <= carry[STAGES-1];
         bus.load_err <= bus.load & (|sat);
      end
   end

endmodule

// File: tb/tb_rtc_cascade_counter.sv
// Self-checking bench for rtc_cascade_counter in its hh:mm:ss configuration;
// the reference model treats the chain as one mixed-radix seconds-of-day number.
module tb_rtc_cascade_counter;

   localparam int          STAGES = 3;
   localparam int          WIDTH  = 6;
   localparam logic [23:0] MODULI = {8'd24, 8'd60, 8'd60};

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   rtc_cascade_counter_if #(.STAGES(STAGES), .WIDTH(WIDTH)) bus ();

   rtc_cascade_counter #(
      .STAGES (STAGES),
      .WIDTH  (WIDTH),
      .MODULI (MODULI)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int mods[STAGES] = '{60, 60, 24};
   int m_total = 0;
   bit m_wrap  = 1'b0;
   bit m_err   = 1'b0;

   function automatic int span(input int k);
      int p = 1;
      for (int i = 0; i <= k; i++) p = p * mods[i];
      return p;
   endfunction

   function automatic logic [STAGES*WIDTH-1:0] pack_total(input int t);
      logic [STAGES*WIDTH-1:0] v = '0;
      int r = t;
      for (int k = 0; k < STAGES; k++) begin
         v[WIDTH*k +: WIDTH] = WIDTH'(r % mods[k]);
         r = r / mods[k];
      end
      return v;
   endfunction

   function automatic logic [STAGES*WIDTH-1:0] hms(input int h, input int m, input int s);
      return {WIDTH'(h), WIDTH'(m), WIDTH'(s)};
   endfunction

   // Stages 0..k sit at their terminal value exactly when the low part of the
   // total is all-max (counting up) or all-zero (counting down).
   function automatic logic [STAGES-1:0] exp_carry();
      logic [STAGES-1:0] c = '0;
      if (bus.en && !bus.load) begin
         for (int k = 0; k < STAGES; k++) begin
            if (bus.up_dn) c[k] = (((m_total + 1) % span(k)) == 0);
            else           c[k] = ((m_total % span(k)) == 0);
         end
      end
      return c;
   endfunction

   task automatic model_clock();
      logic [STAGES-1:0] c;
      int t;
      int w;
      int f;
      if (!rst) begin
         m_total = 0;
         m_wrap  = 1'b0;
         m_err   = 1'b0;
      end else if (bus.load) begin
         t     = 0;
         w     = 1;
         m_err = 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            f = int'(bus.load_val[WIDTH*k +: WIDTH]);
            if (f >= mods[k]) begin
               f     = mods[k] - 1;
               m_err = 1'b1;
            end
            t = t + f * w;
            w = w * mods[k];
         end
         m_total = t;
         m_wrap  = 1'b0;
      end else if (bus.en) begin
         c       = exp_carry();
         m_wrap  = c[STAGES-1];
         m_err   = 1'b0;
         if (bus.up_dn) m_total = (m_total + 1) % span(STAGES-1);
         else           m_total = (m_total - 1 + span(STAGES-1)) % span(STAGES-1);
      end else begin
         m_wrap = 1'b0;
         m_err  = 1'b0;
      end
   endtask

   task automatic applyStimulus(input logic en, input logic up, input logic ld,
                                input logic [STAGES*WIDTH-1:0] lv);
      bus.en       = en;
      bus.up_dn    = up;
      bus.load     = ld;
      bus.load_val = lv;
   endtask

   task automatic step_clk();
      model_clock();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, hms(5, 5, 5));
      for (int i = 0; i < 2; i++) begin
         step_clk();
         n_checks++;
         if (bus.count !== hms(0, 0, 0)) begin
            n_fail++;
            $display("[TB] FAIL reset_count: got %h want %h", bus.count, hms(0, 0, 0));
         end
         n_checks++;
         if (bus.wrap !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_wrap: got %b want 0", bus.wrap);
         end
      end
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      step_clk();
      n_checks++;
      if (bus.count !== hms(0, 0, 1)) begin
         n_fail++;
         $display("[TB] FAIL reset_release: got %h want %h", bus.count, hms(0, 0, 1));
      end
   endtask

   task automatic test_up_rollover();
      applyStimulus(1'b0, 1'b1, 1'b1, hms(23, 59, 59));
      step_clk();
      n_checks++;
      if (bus.count !== hms(23, 59, 59) || bus.load_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL up_load: got %h err %b want %h err 0", bus.count, bus.load_err, hms(23, 59, 59));
      end
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      #1;
      n_checks++;
      if (bus.carry !== 3'b111) begin
         n_fail++;
         $display("[TB] FAIL up_carry: got %b want 111", bus.carry);
      end
      step_clk();
      n_checks++;
      if (bus.count !== hms(0, 0, 0) || bus.wrap !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL up_wrap: got %h wrap %b want %h wrap 1", bus.count, bus.wrap, hms(0, 0, 0));
      end
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      step_clk();
      n_checks++;
      if (bus.wrap !== 1'b0 || bus.count !== hms(0, 0, 0)) begin
         n_fail++;
         $display("[TB] FAIL up_wrap_once: got %h wrap %b want %h wrap 0", bus.count, bus.wrap, hms(0, 0, 0));
      end
   endtask

   task automatic test_down_rollover();
      applyStimulus(1'b0, 1'b0, 1'b1, hms(0, 0, 0));
      step_clk();
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      #1;
      n_checks++;
      if (bus.carry !== 3'b111) begin
         n_fail++;
         $display("[TB] FAIL down_carry: got %b want 111", bus.carry);
      end
      step_clk();
      n_checks++;
      if (bus.count !== hms(23, 59, 59) || bus.wrap !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL down_wrap: got %h wrap %b want %h wrap 1", bus.count, bus.wrap, hms(23, 59, 59));
      end
      step_clk();
      n_checks++;
      if (bus.count !== hms(23, 59, 58) || bus.wrap !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL down_next: got %h wrap %b want %h wrap 0", bus.count, bus.wrap, hms(23, 59, 58));
      end
   endtask

   task automatic test_minute_carry();
      applyStimulus(1'b0, 1'b1, 1'b1, hms(5, 10, 59));
      step_clk();
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      #1;
      n_checks++;
      if (bus.carry !== 3'b001) begin
         n_fail++;
         $display("[TB] FAIL minute_carry: got %b want 001", bus.carry);
      end
      step_clk();
      n_checks++;
      if (bus.count !== hms(5, 11, 0) || bus.wrap !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL minute_count: got %h wrap %b want %h wrap 0", bus.count, bus.wrap, hms(5, 11, 0));
      end
   endtask

   task automatic test_saturating_load();
      applyStimulus(1'b1, 1'b1, 1'b1, hms(30, 45, 63));
      #1;
      n_checks++;
      if (bus.carry !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL load_carry: got %b want 000", bus.carry);
      end
      step_clk();
      n_checks++;
      if (bus.count !== hms(23, 45, 59) || bus.load_err !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL sat_load: got %h err %b want %h err 1", bus.count, bus.load_err, hms(23, 45, 59));
      end
      applyStimulus(1'b0, 1'b1, 1'b1, hms(1, 2, 3));
      step_clk();
      n_checks++;
      if (bus.count !== hms(1, 2, 3) || bus.load_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL legal_load: got %h err %b want %h err 0", bus.count, bus.load_err, hms(1, 2, 3));
      end
      applyStimulus(1'b0, 1'b1, 1'b1, hms(0, 60, 0));
      step_clk();
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      step_clk();
      n_checks++;
      if (bus.load_err !== 1'b0 || bus.count !== hms(0, 59, 0)) begin
         n_fail++;
         $display("[TB] FAIL err_pulse: got %h err %b want %h err 0", bus.count, bus.load_err, hms(0, 59, 0));
      end
   endtask

   task automatic test_hold_flip();
      applyStimulus(1'b0, 1'b1, 1'b1, hms(12, 0, 0));
      step_clk();
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 10; i++) begin
         bus.up_dn = i[0];
         step_clk();
      end
      n_checks++;
      if (bus.count !== hms(12, 0, 0) || bus.wrap !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL hold: got %h wrap %b want %h", bus.count, bus.wrap, hms(12, 0, 0));
      end
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      step_clk();
      n_checks++;
      if (bus.count !== hms(12, 0, 1)) begin
         n_fail++;
         $display("[TB] FAIL flip_up: got %h want %h", bus.count, hms(12, 0, 1));
      end
      bus.up_dn = 1'b0;
      step_clk();
      n_checks++;
      if (bus.count !== hms(12, 0, 0)) begin
         n_fail++;
         $display("[TB] FAIL flip_down: got %h want %h", bus.count, hms(12, 0, 0));
      end
      bus.up_dn = 1'b1;
      step_clk();
      n_checks++;
      if (bus.count !== hms(12, 0, 1)) begin
         n_fail++;
         $display("[TB] FAIL flip_up2: got %h want %h", bus.count, hms(12, 0, 1));
      end
   endtask

   // Random mix biased towards counting, with occasional loads and resets.
   task automatic test_random();
      logic [STAGES-1:0] c;
      applyStimulus(1'b0, 1'b1, 1'b1, hms(23, 59, 50));
      step_clk();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) != 0);
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                       $urandom_range(0, 11) == 0, (STAGES*WIDTH)'($urandom));
         #1;
         c = exp_carry();
         n_checks++;
         if (bus.carry !== c) begin
            n_fail++;
            $display("[TB] FAIL rand_carry[%0d]: got %b want %b", i, bus.carry, c);
         end
         step_clk();
         n_checks++;
         if (bus.count !== pack_total(m_total) || bus.wrap !== m_wrap || bus.load_err !== m_err) begin
            n_fail++;
            $display("[TB] FAIL rand_state[%0d]: got %h wrap %b err %b want %h wrap %b err %b",
                     i, bus.count, bus.wrap, bus.load_err, pack_total(m_total), m_wrap, m_err);
         end
      end
      rst = 1'b1;
   endtask

   initial begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      @(posedge clk);
      #1;
      test_reset();
      test_up_rollover();
      test_down_rollover();
      test_minute_carry();
      test_saturating_load();
      test_hold_flip();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
